hazard_ctrl: RTL and testbench

- Central pipeline control unit that drives the stall, flush and hlt inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects three hazard classes and turns them into cycle-exact bubble/hold/flush sequences:
  - load-use data hazards between EX and ID;
  - taken branches resolved in EX;
  - multi-cycle sprite-unit operations.
- Also latches processor halt.
- Sits beside the pipeline registers; consumes decoded ID/EX fields and produces their control inputs.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_match.sv | 26 ++
 rtl/hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard control unit.
// Holds the FSM state encoding and the register-index width.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_BUB = 2'd1,
    SPR_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_ctrl_match.sv
// Load-use comparator between the ID source fields and the EX destination.
// Register 0 is hard-wired, so it never creates a hazard.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  reg_idx_t i_src1,
  input  reg_idx_t i_src2,
  input  logic     i_use_src1,
  input  logic     i_use_src2,
  input  reg_idx_t i_dst,
  input  logic     i_use_dst,
  input  logic     i_mem_re,
  output logic     o_load_use
);

  logic w_dst_ok;
  logic w_match1;
  logic w_match2;

  assign w_dst_ok = i_use_dst & (i_dst != REG_ZERO);
  assign w_match1 = w_dst_ok & i_use_src1 & (i_src1 == i_dst);
  assign w_match2 = w_dst_ok & i_use_src2 & (i_src2 == i_dst);

  assign o_load_use = i_mem_re & (w_match1 | w_match2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/halt controller for IF/ID, ID/EX and EX/MEM.
// Define HAZARD_PERF_CNT_EN to add saturating hazard event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT    = 1,
  parameter int SPR_TIMEOUT = 255
)(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t ID_src1,
  input  reg_idx_t ID_src2,
  input  logic     ID_use_src1,
  input  logic     ID_use_src2,
  input  reg_idx_t EX_dst_reg,
  input  logic     EX_use_dst_reg,
  input  logic     EX_mem_re,
  input  logic     EX_branch_taken,
  input  logic     EX_sprite_start,
  input  logic     sprite_done,
  input  logic     hlt_req,
  output logic     pc_hold,
  output logic     IF_ID_stall,
  output logic     IF_ID_flush,
  output logic     ID_EX_stall,
  output logic     ID_EX_flush,
  output logic     EX_MEM_stall,
  output logic     hlt,
  output logic     spr_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] load_stall_cnt,
  output logic [15:0] spr_stall_cnt,
  output logic [15:0] br_flush_cnt
`endif
);

  localparam logic [1:0] BUB_INIT  = 2'(LOAD_LAT - 1);
  localparam logic [7:0] SPR_LIMIT = 8'(SPR_TIMEOUT);

  state_e     r_state;
  logic [1:0] r_bub;
  logic [7:0] r_cnt;

  logic       w_load_use;
  logic       w_spr_go;
  logic [7:0] w_cnt_inc;
  logic       w_to;

  logic w_pc_hold;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_stall;
  logic w_id_ex_flush;
  logic w_ex_mem_stall;
  logic w_hlt;
  logic w_spr_to;

  hazard_match u_match (
    .i_src1     (ID_src1),
    .i_src2     (ID_src2),
    .i_use_src1 (ID_use_src1),
    .i_use_src2 (ID_use_src2),
    .i_dst      (EX_dst_reg),
    .i_use_dst  (EX_use_dst_reg),
    .i_mem_re   (EX_mem_re),
    .o_load_use (w_load_use)
  );

  assign w_spr_go  = EX_sprite_start & ~sprite_done;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_to      = (w_cnt_inc == SPR_LIMIT);

  always_comb begin
    w_pc_hold      = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_hlt          = 1'b0;
    w_spr_to       = 1'b0;
    unique case (r_state)
      RUN: begin
        if (hlt_req) begin
          w_hlt = 1'b1;
        end else if (EX_branch_taken) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_spr_go) begin
          w_pc_hold      = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
        end else if (w_load_use) begin
          w_pc_hold     = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end
      LOAD_BUB: begin
        w_pc_hold     = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
      end
      SPR_WAIT: begin
        if (!sprite_done) begin
          if (w_to) begin
            w_spr_to = 1'b1;
          end else begin
            w_pc_hold      = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
          end
        end
      end
      HALTED: begin
        w_hlt     = 1'b1;
        w_pc_hold = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_bub   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (hlt_req) begin
            r_state <= HALTED;
          end else if (EX_branch_taken) begin
            r_state <= RUN;
          end else if (w_spr_go) begin
            r_state <= SPR_WAIT;
            r_cnt   <= 8'd0;
          end else if (w_load_use && LOAD_LAT > 1) begin
            r_state <= LOAD_BUB;
            r_bub   <= BUB_INIT;
          end
        end
        LOAD_BUB: begin
          r_bub <= r_bub - 2'd1;
          if (r_bub <= 2'd1) r_state <= RUN;
        end
        SPR_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (sprite_done || w_to) r_state <= RUN;
        end
        HALTED: r_state <= HALTED;
      endcase
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign pc_hold      = rst_n & w_pc_hold;
  assign IF_ID_stall  = rst_n & w_if_id_stall;
  assign IF_ID_flush  = rst_n & w_if_id_flush;
  assign ID_EX_stall  = rst_n & w_id_ex_stall;
  assign ID_EX_flush  = rst_n & w_id_ex_flush;
  assign EX_MEM_stall = rst_n & w_ex_mem_stall;
  assign hlt          = rst_n & w_hlt;
  assign spr_timeout  = rst_n & w_spr_to;

`ifdef HAZARD_PERF_CNT_EN
  logic        w_load_bub;
  logic [15:0] r_load_cnt;
  logic [15:0] r_spr_cnt;
  logic [15:0] r_br_cnt;

  // Only a load bubble raises pc_hold together with an ID/EX flush.
  assign w_load_bub = w_pc_hold & w_id_ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt <= 16'd0;
      r_spr_cnt  <= 16'd0;
      r_br_cnt   <= 16'd0;
    end else begin
      if (w_load_bub && r_load_cnt != 16'hFFFF)
        r_load_cnt <= r_load_cnt + 16'd1;
      if (r_state == SPR_WAIT && r_spr_cnt != 16'hFFFF)
        r_spr_cnt <= r_spr_cnt + 16'd1;
      if (w_if_id_flush && r_br_cnt != 16'hFFFF)
        r_br_cnt <= r_br_cnt + 16'd1;
    end
  end

  assign load_stall_cnt = r_load_cnt;
  assign spr_stall_cnt  = r_spr_cnt;
  assign br_flush_cnt   = r_br_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT 1 and 3).
// Output vector: {pc_hold,IFID_stl,IFID_fl,IDEX_stl,IDEX_fl,EXMEM_stl,hlt,to}.
module tb_hazard_ctrl;

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b1100_1000;
  localparam logic [7:0] O_BR   = 8'b0010_1000;
  localparam logic [7:0] O_SPR  = 8'b1101_0100;
  localparam logic [7:0] O_TO   = 8'b0000_0001;
  localparam logic [7:0] O_HREQ = 8'b0000_0010;
  localparam logic [7:0] O_HALT = 8'b1000_0010;

  typedef struct {
    string      tag;
    logic [7:0] ea;
    logic [7:0] eb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_src1, ID_src2, EX_dst_reg;
  logic       ID_use_src1, ID_use_src2;
  logic       EX_use_dst_reg, EX_mem_re;
  logic       EX_branch_taken, EX_sprite_start;
  logic       sprite_done, hlt_req;

  logic [7:0] obs_a, obs_b;
  exp_t       sb[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .SPR_TIMEOUT(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_use_src1(ID_use_src1), .ID_use_src2(ID_use_src2),
    .EX_dst_reg(EX_dst_reg), .EX_use_dst_reg(EX_use_dst_reg),
    .EX_mem_re(EX_mem_re), .EX_branch_taken(EX_branch_taken),
    .EX_sprite_start(EX_sprite_start), .sprite_done(sprite_done),
    .hlt_req(hlt_req),
    .pc_hold(obs_a[7]), .IF_ID_stall(obs_a[6]),
    .IF_ID_flush(obs_a[5]), .ID_EX_stall(obs_a[4]),
    .ID_EX_flush(obs_a[3]), .EX_MEM_stall(obs_a[2]),
    .hlt(obs_a[1]), .spr_timeout(obs_a[0])
  );

  hazard_ctrl #(.LOAD_LAT(3), .SPR_TIMEOUT(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_use_src1(ID_use_src1), .ID_use_src2(ID_use_src2),
    .EX_dst_reg(EX_dst_reg), .EX_use_dst_reg(EX_use_dst_reg),
    .EX_mem_re(EX_mem_re), .EX_branch_taken(EX_branch_taken),
    .EX_sprite_start(EX_sprite_start), .sprite_done(sprite_done),
    .hlt_req(hlt_req),
    .pc_hold(obs_b[7]), .IF_ID_stall(obs_b[6]),
    .IF_ID_flush(obs_b[5]), .ID_EX_stall(obs_b[4]),
    .ID_EX_flush(obs_b[3]), .EX_MEM_stall(obs_b[2]),
    .hlt(obs_b[1]), .spr_timeout(obs_b[0])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic clr();
    ID_src1 = 5'd0; ID_src2 = 5'd0; EX_dst_reg = 5'd0;
    ID_use_src1 = 1'b0; ID_use_src2 = 1'b0;
    EX_use_dst_reg = 1'b0; EX_mem_re = 1'b0;
    EX_branch_taken = 1'b0; EX_sprite_start = 1'b0;
    sprite_done = 1'b0; hlt_req = 1'b0;
  endtask

  task automatic load(input logic [4:0] dst);
    ID_src2 = dst; ID_use_src2 = 1'b1;
    EX_dst_reg = dst; EX_use_dst_reg = 1'b1; EX_mem_re = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [7:0] ea,
                          input logic [7:0] eb);
    exp_t e;
    e.tag = tag; e.ea = ea; e.eb = eb;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "/a"}, {24'd0, obs_a}, {24'd0, e.ea});
      chk({e.tag, "/b"}, {24'd0, obs_b}, {24'd0, e.eb});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    EX_branch_taken = 1'b1; hlt_req = 1'b1; EX_sprite_start = 1'b1;
    #3;
    chk("rst/a", {24'd0, obs_a}, 32'd0);
    chk("rst/b", {24'd0, obs_b}, 32'd0);
    #5 clr();
    #2 rst_n = 1'b1;

    tick(); expect_o("idle", O_NONE, O_NONE);

    tick(); load(5'd5); expect_o("ld", O_LOAD, O_LOAD);
    tick(); clr(); expect_o("ld+1", O_NONE, O_LOAD);
    tick(); expect_o("ld+2", O_NONE, O_LOAD);
    tick(); expect_o("ld+3", O_NONE, O_NONE);

    tick(); load(5'd0); expect_o("r0", O_NONE, O_NONE);
    tick(); clr(); ID_src1 = 5'd7; EX_dst_reg = 5'd7;
    EX_use_dst_reg = 1'b1; EX_mem_re = 1'b1;
    expect_o("nouse", O_NONE, O_NONE);
    tick(); ID_use_src1 = 1'b1; EX_use_dst_reg = 1'b0;
    expect_o("nodst", O_NONE, O_NONE);
    tick(); EX_use_dst_reg = 1'b1; EX_mem_re = 1'b0;
    expect_o("noload", O_NONE, O_NONE);
    tick(); EX_mem_re = 1'b1; ID_src1 = 5'd6;
    expect_o("diff", O_NONE, O_NONE);
    tick(); ID_src1 = 5'd7; expect_o("ld_s1", O_LOAD, O_LOAD);
    tick(); clr(); expect_o("ld_s1+1", O_NONE, O_LOAD);
    tick(); expect_o("ld_s1+2", O_NONE, O_LOAD);
    tick(); expect_o("ld_s1+3", O_NONE, O_NONE);

    tick(); load(5'd9); EX_branch_taken = 1'b1;
    expect_o("br", O_BR, O_BR);
    tick(); clr(); expect_o("br+1", O_NONE, O_NONE);

    tick(); EX_sprite_start = 1'b1; expect_o("spr0", O_SPR, O_SPR);
    for (int i = 1; i < 4; i++) begin
      tick(); expect_o("spr_w", O_SPR, O_SPR);
    end
    tick(); sprite_done = 1'b1; expect_o("spr_done", O_NONE, O_NONE);
    tick(); clr(); expect_o("spr_run", O_NONE, O_NONE);

    tick(); EX_sprite_start = 1'b1; sprite_done = 1'b1;
    expect_o("spr_same", O_NONE, O_NONE);
    tick(); clr(); expect_o("spr_same+1", O_NONE, O_NONE);

    tick(); EX_sprite_start = 1'b1; expect_o("to0", O_SPR, O_SPR);
    for (int i = 1; i < 10; i++) begin
      tick();
      hlt_req = (i == 3 || i == 4);
      expect_o("to_w", O_SPR, O_SPR);
    end
    tick(); clr(); expect_o("to", O_TO, O_TO);
    tick(); expect_o("to+1", O_NONE, O_NONE);

    tick(); EX_sprite_start = 1'b1; expect_o("rs0", O_SPR, O_SPR);
    tick(); clr(); expect_o("rs1", O_SPR, O_SPR);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst/a", {24'd0, obs_a}, 32'd0);
    chk("arst/b", {24'd0, obs_b}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(); expect_o("post_rst", O_NONE, O_NONE);

    tick(); hlt_req = 1'b1; EX_branch_taken = 1'b1;
    expect_o("hreq", O_HREQ, O_HREQ);
    tick(); clr(); expect_o("halt1", O_HALT, O_HALT);
    tick(); EX_branch_taken = 1'b1; EX_sprite_start = 1'b1;
    expect_o("halt2", O_HALT, O_HALT);
    tick(); clr(); load(5'd3); expect_o("halt3", O_HALT, O_HALT);

    @(negedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
